// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: instruction field map,
// class and ALU-op codes, FSM state encoding.
package seq_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RC_W    = 16;

    // Instruction field positions
    localparam int unsigned CLS_MSB = 31;
    localparam int unsigned CLS_LSB = 30;
    localparam int unsigned OP_MSB  = 29;
    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned RD_MSB  = 27;
    localparam int unsigned RD_LSB  = 23;
    localparam int unsigned RS1_MSB = 22;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_MSB = 17;
    localparam int unsigned RS2_LSB = 13;
    localparam int unsigned CNT_MSB = 12;
    localparam int unsigned CNT_LSB = 8;
    localparam int unsigned IMM_MSB = 22;
    localparam int unsigned IMM_LSB = 0;

    // Instruction classes
    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_LDI = 2'b01,
        CLS_REP = 2'b10,
        CLS_CMP = 2'b11
    } cls_e;

    // ALU operation codes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // Register-form instruction word; LDI reuses bits [22:0] as immediate
    typedef struct packed {
        cls_e       cls;
        logic [1:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] cnt;
        logic [7:0] rsvd;
    } instr_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: maps an instruction word onto the
// control values the sequencer loads when it accepts the instruction.
module seq_decode
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  instr_t              instr,
    output cls_e                cls_c,
    output logic [ADDR_W-1:0]   rd_c,
    output logic [ADDR_W-1:0]   rs1_c,
    output logic [ADDR_W-1:0]   rs2_c,
    output logic                we_c,
    output logic                mux_c,
    output logic [1:0]          op_c,
    output logic [DATA_W-1:0]   imm_c,
    output logic [CNT_W-1:0]    cnt_c
);

    // Per-class control values; register form is the default
    always_comb begin
        cls_c = instr.cls;
        op_c  = instr.op;
        rd_c  = ADDR_W'(instr.rd);
        rs1_c = ADDR_W'(instr.rs1);
        rs2_c = ADDR_W'(instr.rs2);
        we_c  = 1'b0;
        mux_c = 1'b1;
        imm_c = '0;
        cnt_c = '0;
        unique case (instr.cls)
            CLS_ALU: we_c = 1'b1;
            CLS_LDI: begin
                we_c  = 1'b1;
                mux_c = 1'b0;
                rs1_c = '0;
                rs2_c = '0;
                imm_c = DATA_W'(instr[IMM_MSB:IMM_LSB]);
            end
            CLS_REP: begin
                we_c  = 1'b1;
                cnt_c = CNT_W'(instr.cnt);
            end
            CLS_CMP: we_c = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control stage in front of the register-file/ALU datapath.
// Accepts one instruction per handshake, then drives the datapath controls
// for one EXEC cycle (count+1 cycles for REP) before retiring with Done.
// Optional: define SEQ_PERF_CNT_EN to enable the saturating retired counter.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [INSTR_W-1:0]  Instr_in,
    input  logic                Instr_valid,
    output logic                Instr_ready,
    input  logic                zero_flag,
    output logic [ADDR_W-1:0]   Read_Addr_1,
    output logic [ADDR_W-1:0]   Read_Addr_2,
    output logic [ADDR_W-1:0]   Write_Addr,
    output logic                Write_Enable,
    output logic                Mux_cntrl,
    output logic [1:0]          opcode,
    output logic [DATA_W-1:0]   Imm_Out,
    output logic                Z_out,
    output logic                Done,
    output logic [RC_W-1:0]     Retired_Count
);

    state_e              state_q, state_d;
    cls_e                cls_q, cls_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rdy_en_q;

    logic [ADDR_W-1:0]   ra1_d, ra2_d, wa_d;
    logic                we_d, mux_d, z_d, done_d;
    logic [1:0]          op_d;
    logic [DATA_W-1:0]   imm_d;

    cls_e                dec_cls;
    logic [ADDR_W-1:0]   dec_rd, dec_rs1, dec_rs2;
    logic                dec_we, dec_mux;
    logic [1:0]          dec_op;
    logic [DATA_W-1:0]   dec_imm;
    logic [CNT_W-1:0]    dec_cnt;

    logic                accept_c;
    logic                last_c;

    seq_decode #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_decode (
        .instr  (instr_t'(Instr_in)),
        .cls_c  (dec_cls),
        .rd_c   (dec_rd),
        .rs1_c  (dec_rs1),
        .rs2_c  (dec_rs2),
        .we_c   (dec_we),
        .mux_c  (dec_mux),
        .op_c   (dec_op),
        .imm_c  (dec_imm),
        .cnt_c  (dec_cnt)
    );

    // Ready only in IDLE, and held low for the first cycle after reset
    assign Instr_ready = rdy_en_q && (state_q == S_IDLE);
    assign accept_c    = Instr_valid && Instr_ready;
    assign last_c      = (cls_q != CLS_REP) || (cnt_q == '0);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept_c) state_d = S_EXEC;
            S_EXEC: if (last_c)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the control/output registers
    always_comb begin
        ra1_d  = Read_Addr_1;
        ra2_d  = Read_Addr_2;
        wa_d   = Write_Addr;
        we_d   = Write_Enable;
        mux_d  = Mux_cntrl;
        op_d   = opcode;
        imm_d  = Imm_Out;
        z_d    = Z_out;
        done_d = 1'b0;
        cls_d  = cls_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    ra1_d = dec_rs1;
                    ra2_d = dec_rs2;
                    wa_d  = dec_rd;
                    we_d  = dec_we;
                    mux_d = dec_mux;
                    op_d  = dec_op;
                    imm_d = dec_imm;
                    cls_d = dec_cls;
                    cnt_d = dec_cnt;
                end
            end
            S_EXEC: begin
                if (cls_q == CLS_CMP) z_d = zero_flag;
                if (last_c) begin
                    we_d   = 1'b0;
                    mux_d  = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and control registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdy_en_q     <= 1'b0;
            Read_Addr_1  <= '0;
            Read_Addr_2  <= '0;
            Write_Addr   <= '0;
            Write_Enable <= 1'b0;
            Mux_cntrl    <= 1'b0;
            opcode       <= '0;
            Imm_Out      <= '0;
            Z_out        <= 1'b0;
            Done         <= 1'b0;
            cls_q        <= CLS_ALU;
            cnt_q        <= '0;
        end else begin
            rdy_en_q     <= 1'b1;
            Read_Addr_1  <= ra1_d;
            Read_Addr_2  <= ra2_d;
            Write_Addr   <= wa_d;
            Write_Enable <= we_d;
            Mux_cntrl    <= mux_d;
            opcode       <= op_d;
            Imm_Out      <= imm_d;
            Z_out        <= z_d;
            Done         <= done_d;
            cls_q        <= cls_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [RC_W-1:0] retired_q;

    // Saturating count of Done pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            retired_q <= '0;
        end else if (Done && (retired_q != '1)) begin
            retired_q <= retired_q + RC_W'(1);
        end
    end

    assign Retired_Count = retired_q;
`else
    assign Retired_Count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a simple register-file/ALU datapath closes the
// loop, and an instruction-level model predicts register contents, Z_out,
// write counts and retire timing.
module tb_instr_sequencer;
    import seq_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr_in = '0;
    logic        Instr_valid = 1'b0;
    logic        Instr_ready;
    logic        zero_flag;
    logic [4:0]  Read_Addr_1, Read_Addr_2, Write_Addr;
    logic        Write_Enable, Mux_cntrl;
    logic [1:0]  opcode;
    logic [31:0] Imm_Out;
    logic        Z_out, Done;
    logic [15:0] Retired_Count;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clock = ~Clock;

    instr_sequencer dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Instr_in      (Instr_in),
        .Instr_valid   (Instr_valid),
        .Instr_ready   (Instr_ready),
        .zero_flag     (zero_flag),
        .Read_Addr_1   (Read_Addr_1),
        .Read_Addr_2   (Read_Addr_2),
        .Write_Addr    (Write_Addr),
        .Write_Enable  (Write_Enable),
        .Mux_cntrl     (Mux_cntrl),
        .opcode        (opcode),
        .Imm_Out       (Imm_Out),
        .Z_out         (Z_out),
        .Done          (Done),
        .Retired_Count (Retired_Count)
    );

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_OR:   return a | b;
            OP_SUB:  return a - b;
            default: return a & b;
        endcase
    endfunction

    // Datapath: register file, ALU and write mux driven by the DUT
    logic [31:0] rf [32] = '{default: '0};
    logic [31:0] alu_res;
    int wr_cnt = 0;
    int done_cnt = 0;

    assign alu_res   = alu_f(opcode, rf[Read_Addr_1], rf[Read_Addr_2]);
    assign zero_flag = (alu_res == 32'd0);

    always @(posedge Clock) begin
        if (Write_Enable) begin
            rf[Write_Addr] <= Mux_cntrl ? alu_res : Imm_Out;
            wr_cnt <= wr_cnt + 1;
        end
        if (Done) done_cnt <= done_cnt + 1;
    end

    // Instruction-level reference model
    logic [31:0] m [32] = '{default: '0};
    logic        mz = 1'b0;
    int          exp_ret = 0;

    function automatic logic [31:0] mk(input logic [1:0] cls, input logic [1:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] cnt);
        return {cls, op, rd, rs1, rs2, cnt, 8'h00};
    endfunction

    function automatic logic [31:0] mk_ldi(input logic [4:0] rd, input logic [22:0] imm);
        return {2'b01, 2'b00, rd, imm};
    endfunction

    function automatic int iters_of(input logic [31:0] ins);
        return (ins[31:30] == 2'b10) ? int'(ins[12:8]) + 1 : 1;
    endfunction

    function automatic logic [31:0] exp_retired();
`ifdef SEQ_PERF_CNT_EN
        return (exp_ret > 65535) ? 32'd65535 : 32'(exp_ret);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_exec(input logic [31:0] ins, input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = alu_f(ins[29:28], m[ins[22:18]], m[ins[17:13]]);
            case (ins[31:30])
                2'b01:   m[ins[27:23]] = {9'd0, ins[22:0]};
                2'b11:   mz = (r == 32'd0);
                default: m[ins[27:23]] = r;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [1:0] cls;
        cls = 2'($urandom_range(0, 3));
        if (cls == 2'b01) return mk_ldi(5'($urandom_range(8, 15)), 23'($urandom()));
        return mk(cls, 2'($urandom_range(0, 3)), 5'($urandom_range(8, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 7)));
    endfunction

    // Issue one instruction, follow it to retirement, check against the model
    task automatic run_instr(input logic [31:0] ins);
        int c, ex, wr0, dn0, it, nwr;
        logic [1:0]  cls;
        logic [31:0] exp_ctl, obs_ctl, exp_imm;
        cls = ins[31:30];
        it  = iters_of(ins);
        nwr = (cls == 2'b11) ? 0 : it;
        Instr_in    = ins;
        Instr_valid = 1'b1;
        c = 0;
        while (Instr_ready !== 1'b1 && c < 20) begin
            @(negedge Clock);
            c++;
        end
        chk("accept_wait", 32'(c < 20), 32'd1);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        @(negedge Clock);
        Instr_valid = 1'($urandom_range(0, 1));
        Instr_in    = $urandom();
        exp_ctl = 32'({cls != 2'b11, cls != 2'b01, ins[29:28],
                       (cls == 2'b11) ? 5'd0 : ins[27:23],
                       (cls == 2'b01) ? 5'd0 : ins[22:18],
                       (cls == 2'b01) ? 5'd0 : ins[17:13]});
        obs_ctl = 32'({Write_Enable, Mux_cntrl, opcode,
                       (cls == 2'b11) ? 5'd0 : Write_Addr, Read_Addr_1, Read_Addr_2});
        exp_imm = (cls == 2'b01) ? {9'd0, ins[22:0]} : 32'd0;
        chk("exec_ctl", obs_ctl, exp_ctl);
        chk("exec_imm", Imm_Out, exp_imm);
        chk("exec_ready", 32'(Instr_ready), 32'd0);
        c  = 1;
        ex = 1;
        while (Done !== 1'b1 && c < 40) begin
            @(negedge Clock);
            c++;
            if (c == 2) Instr_valid = 1'b0;
            if (Done !== 1'b1 && Instr_ready === 1'b0) ex++;
        end
        chk("done_cycle", 32'(c), 32'(it + 1));
        chk("exec_cycles", 32'(ex), 32'(it));
        chk("writes", 32'(wr_cnt - wr0), 32'(nwr));
        chk("done_ctl", 32'({Write_Enable, Mux_cntrl, Instr_ready}), 32'b001);
        model_exec(ins, it);
        exp_ret++;
        @(negedge Clock);
        chk("done_low", 32'(Done), 32'd0);
        chk("done_once", 32'(done_cnt - dn0), 32'd1);
        chk("rf_rd", rf[ins[27:23]], m[ins[27:23]]);
        chk("z_out", 32'(Z_out), 32'(mz));
        chk("retired", 32'(Retired_Count), exp_retired());
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] b2b [4];
        int acc_c [4];
        int idx, c, wr0, dn0;
        logic acc;

        // Power-up reset
        repeat (2) @(negedge Clock);
        chk("rst_ctl", 32'({Instr_ready, Read_Addr_1, Read_Addr_2, Write_Addr, Write_Enable,
                            Mux_cntrl, opcode, Z_out, Done}), 32'd0);
        chk("rst_imm", Imm_Out, 32'd0);
        chk("rst_ret", 32'(Retired_Count), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_ready_rise", 32'(Instr_ready), 32'd1);

        // Directed program
        run_instr(mk_ldi(5'd3, 23'd5));
        chk("r3_eq_5", rf[3], 32'd5);
        run_instr(mk(CLS_ALU, OP_ADD, 5'd4, 5'd3, 5'd3, 5'd0));
        chk("r4_eq_10", rf[4], 32'd10);
        run_instr(mk(CLS_REP, OP_ADD, 5'd4, 5'd4, 5'd3, 5'd2));
        chk("r4_eq_25", rf[4], 32'd25);
        run_instr(mk(CLS_CMP, OP_SUB, 5'd0, 5'd3, 5'd3, 5'd0));
        chk("z_eq_1", 32'(Z_out), 32'd1);
        run_instr(mk(CLS_CMP, OP_SUB, 5'd0, 5'd4, 5'd3, 5'd0));
        chk("z_eq_0", 32'(Z_out), 32'd0);
        run_instr(mk(CLS_REP, OP_OR, 5'd6, 5'd3, 5'd4, 5'd0));
        run_instr(mk(CLS_REP, OP_ADD, 5'd7, 5'd7, 5'd3, 5'd31));
        chk("r7_eq_160", rf[7], 32'd160);

        // Back-to-back with Instr_valid held high
        b2b[0] = mk(CLS_ALU, OP_ADD, 5'd10, 5'd3, 5'd3, 5'd0);
        b2b[1] = mk(CLS_ALU, OP_OR,  5'd11, 5'd10, 5'd4, 5'd0);
        b2b[2] = mk(CLS_ALU, OP_SUB, 5'd12, 5'd11, 5'd3, 5'd0);
        b2b[3] = mk(CLS_ALU, OP_AND, 5'd13, 5'd12, 5'd11, 5'd0);
        dn0 = done_cnt;
        idx = 0;
        c   = 0;
        Instr_in    = b2b[0];
        Instr_valid = 1'b1;
        while (idx < 4 && c < 20) begin
            acc = Instr_ready;
            @(negedge Clock);
            c++;
            if (acc) begin
                acc_c[idx] = c;
                model_exec(b2b[idx], 1);
                exp_ret++;
                idx++;
                if (idx < 4) Instr_in = b2b[idx];
                else Instr_valid = 1'b0;
            end
        end
        chk("b2b_accepted", 32'(idx), 32'd4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc_c[i] - acc_c[i-1]), 32'd2);
        repeat (3) @(negedge Clock);
        chk("b2b_dones", 32'(done_cnt - dn0), 32'd4);
        for (int i = 10; i < 14; i++) chk("b2b_rf", rf[i], m[i]);
        chk("b2b_retired", 32'(Retired_Count), exp_retired());

        // Randomized instructions
        repeat (30) run_instr(rand_instr());

        // Reset in the 5th EXEC cycle of a 32-iteration REP
        ins = mk(CLS_REP, OP_ADD, 5'd5, 5'd5, 5'd3, 5'd31);
        Instr_in    = ins;
        Instr_valid = 1'b1;
        c = 0;
        while (Instr_ready !== 1'b1 && c < 20) begin
            @(negedge Clock);
            c++;
        end
        chk("rmid_accept", 32'(c < 20), 32'd1);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        @(negedge Clock);
        Instr_valid = 1'b0;
        repeat (4) @(negedge Clock);
        chk("rmid_we", 32'(Write_Enable), 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("rmid_ctl", 32'({Instr_ready, Read_Addr_1, Read_Addr_2, Write_Addr, Write_Enable,
                             Mux_cntrl, opcode, Z_out, Done}), 32'd0);
        chk("rmid_imm", Imm_Out, 32'd0);
        chk("rmid_ret", 32'(Retired_Count), 32'd0);
        chk("rmid_writes", 32'(wr_cnt - wr0), 32'd5);
        Reset = 1'b0;
        model_exec(ins, 5);
        mz = 1'b0;
        exp_ret = 0;
        @(negedge Clock);
        chk("rmid_ready", 32'(Instr_ready), 32'd1);
        repeat (2) @(negedge Clock);
        chk("rmid_nodone", 32'(done_cnt - dn0), 32'd0);
        chk("rmid_nowrite", 32'(wr_cnt - wr0), 32'd5);
        chk("rmid_rf", rf[5], m[5]);
        chk("r5_eq_25", rf[5], 32'd25);

        // Reset and Instr_valid together: instruction must be dropped
        wr0 = wr_cnt;
        dn0 = done_cnt;
        Instr_in    = mk_ldi(5'd9, 23'h1234);
        Instr_valid = 1'b1;
        Reset       = 1'b1;
        @(negedge Clock);
        Reset       = 1'b0;
        Instr_valid = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rwin_nowrite", 32'(wr_cnt - wr0), 32'd0);
        chk("rwin_nodone", 32'(done_cnt - dn0), 32'd0);
        chk("rwin_rf", rf[9], m[9]);
        run_instr(mk(CLS_ALU, OP_SUB, 5'd14, 5'd7, 5'd4, 5'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
